// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {ST_IDLE, ST_BURST} arb_state_t;

  localparam int MAX_REQ   = 8;
  localparam int MAX_BURST = 16;

  // Index width for n requesters (n limited to 2..MAX_REQ).
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2((n > MAX_REQ) ? MAX_REQ : n);
  endfunction

  // Beat counter must hold the value BURST itself.
  function automatic int cnt_w(input int b);
    return $clog2(((b > MAX_BURST) ? MAX_BURST : b) + 1);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Rotate-priority search: first asserted req starting at last+1, wrapping.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last,
  output logic               found,
  output logic [IW-1:0]      idx
);

  // Scan farthest-first so the nearest candidate after last wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      logic [IW-1:0] j;
      j = IW'((int'(last) + k) % NUM_REQ);
      if (req[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for a shared FIFO write port.
// Optional FIFO_ARB_STATS_EN adds a saturating full-stall counter output.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST      = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          busy,
`ifdef FIFO_ARB_STATS_EN
  output logic [15:0]                   stall_cnt,
`endif
  input  logic                          fifo_full,
  output logic                          fifo_w_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in
);

  localparam int IW = idx_w(NUM_REQ);
  localparam int CW = cnt_w(BURST);
  localparam logic [CW-1:0] BURST_C = CW'(BURST);

  arb_state_t    state;
  logic [IW-1:0] owner, last;
  logic [CW-1:0] beat_cnt;
  logic          found;
  logic [IW-1:0] pick;
  logic [CW-1:0] next_cnt;

  rr_picker #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .req   (req),
    .last  (last),
    .found (found),
    .idx   (pick)
  );

  assign next_cnt = beat_cnt + CW'(1);

  // Grants are gated by rst_n so nothing reaches the FIFO during reset.
  always_comb begin
    gnt = '0;
    if (rst_n && !fifo_full) begin
      if (state == ST_IDLE) begin
        if (found) gnt[pick] = 1'b1;
      end else if (req[owner]) begin
        gnt[owner] = 1'b1;
      end
    end
  end

  assign fifo_w_en = |gnt;

  always_comb begin
    fifo_data_in = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt[i]) fifo_data_in = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      owner    <= '0;
      last     <= IW'(NUM_REQ - 1);
      beat_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (found && !fifo_full) begin
            owner    <= pick;
            beat_cnt <= CW'(1);
            if (BURST > 1) begin
              state <= ST_BURST;
              busy  <= 1'b1;
            end else begin
              last <= pick;
            end
          end
        end
        default: begin
          if (req[owner]) begin
            if (!fifo_full) begin
              beat_cnt <= next_cnt;
              if (next_cnt == BURST_C) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
                last  <= owner;
              end
            end
          end else begin
            // Owner dropped early: give up the slot, re-arbitrate next cycle.
            state <= ST_IDLE;
            busy  <= 1'b0;
            last  <= owner;
          end
        end
      endcase
    end
  end

`ifdef FIFO_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (|req && fifo_full && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed scenarios plus random traffic.
module tb_fifo_wr_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int B = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     gnt;
  logic             busy;
  logic             fifo_full;
  logic             fifo_w_en;
  logic [W-1:0]     fifo_data_in;
`ifdef FIFO_ARB_STATS_EN
  logic [15:0]      stall_cnt;
`endif

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .BURST(B)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .req_data     (req_data),
    .gnt          (gnt),
    .busy         (busy),
`ifdef FIFO_ARB_STATS_EN
    .stall_cnt    (stall_cnt),
`endif
    .fifo_full    (fifo_full),
    .fifo_w_en    (fifo_w_en),
    .fifo_data_in (fifo_data_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    int         idx;
    logic [W-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  // Reference model: who owns the port, how many beats taken, who went last.
  bit m_busy;
  int m_owner, m_last, m_beats, m_stall;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req_v);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_last = N - 1; m_beats = 0; m_stall = 0;
  endtask

  // Called #1 after a rising edge: check registered outputs, drive, predict, advance.
  task automatic cycle(input logic [N-1:0] r, input logic [N*W-1:0] d, input logic f);
    int g;
    exp_t e;
    check("busy", 64'(busy), 64'(m_busy));
`ifdef FIFO_ARB_STATS_EN
    check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
    req = r; req_data = d; fifo_full = f;
    g = -1;
    if (!m_busy) begin
      int cand;
      cand = -1;
      for (int k = N; k >= 1; k--)
        if (r[(m_last + k) % N]) cand = (m_last + k) % N;
      if (cand >= 0 && !f) begin
        g = cand; m_owner = cand; m_beats = 1;
        if (B > 1) m_busy = 1; else m_last = cand;
      end
    end else if (!r[m_owner]) begin
      m_busy = 0; m_last = m_owner;
    end else if (!f) begin
      g = m_owner; m_beats++;
      if (m_beats == B) begin m_busy = 0; m_last = m_owner; end
    end
    if (g >= 0) begin
      e.cyc = cyc; e.idx = g; e.data = d[g*W +: W];
      exp_q.push_back(e);
    end
    if (r != 0 && f && m_stall < 16'hFFFF) m_stall++;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic do_reset(input logic [N-1:0] r);
    req = r; req_data = {N*W{1'b1}}; fifo_full = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_gnt", 64'(gnt), 64'd0);
    check("rst_wen", 64'(fifo_w_en), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_data", 64'(fifo_data_in), 64'd0);
    @(posedge clk); #1;
    cyc++;
    model_reset();
    rst_n = 1'b1;
  endtask

  // Monitor: pop on every write; otherwise outputs must be idle.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (fifo_w_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 64'(gnt), 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("write_cycle", 64'(cyc), 64'(e.cyc));
          check("gnt", 64'(gnt), 64'(1) << e.idx);
          check("data", 64'(fifo_data_in), 64'(e.data));
        end
      end else begin
        check("idle_gnt", 64'(gnt), 64'd0);
        check("idle_data", 64'(fifo_data_in), 64'd0);
      end
    end
  end

  initial begin
    logic [N*W-1:0] d;
    rst_n = 1'b0; req = '0; req_data = '0; fifo_full = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    check("por_gnt", 64'(gnt), 64'd0);
    check("por_busy", 64'(busy), 64'd0);
    check("por_wen", 64'(fifo_w_en), 64'd0);
    rst_n = 1'b1;

    // Single requester, four-beat burst then re-grant.
    for (int i = 0; i < 5; i++) cycle(4'b0001, {24'h0, 8'hA5 + 8'(i)}, 1'b0);
    cycle(4'b0000, '0, 1'b0);

    // Full contention from reset: strict 0,1,2,3 rotation of bursts.
    do_reset(4'b0000);
    for (int i = 0; i < 16; i++) cycle(4'b1111, {8'h30 + 8'(i), 8'h20 + 8'(i), 8'h10 + 8'(i), 8'(i)}, 1'b0);
    cycle(4'b0000, '0, 1'b0);

    // Owner 1 stalled by full after beat 2.
    do_reset(4'b0000);
    cycle(4'b0010, 32'h0000_1100, 1'b0);
    cycle(4'b0010, 32'h0000_1200, 1'b0);
    for (int i = 0; i < 3; i++) cycle(4'b0010, 32'h0000_EE00, 1'b1);
    cycle(4'b0010, 32'h0000_1300, 1'b0);
    cycle(4'b0010, 32'h0000_1400, 1'b0);
    cycle(4'b0000, '0, 1'b0);

    // Owner 2 drops after one beat: bubble, then requester 3.
    cycle(4'b0100, 32'h0022_0000, 1'b0);
    cycle(4'b1000, 32'h3300_0000, 1'b0);
    cycle(4'b1000, 32'h3400_0000, 1'b0);
    // Mid-burst reset on beat 2 of owner 3, then requester 0 first.
    do_reset(4'b1111);
    cycle(4'b1111, 32'h4433_2211, 1'b0);
    cycle(4'b0000, '0, 1'b0);

    // Full with a pending request: no writes, stall count grows.
    for (int i = 0; i < 10; i++) cycle(4'b0001, 32'h0000_00FF, 1'b1);
    cycle(4'b0000, '0, 1'b0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(499) == 0) begin
        do_reset(N'($urandom));
      end else begin
        d = $urandom;
        cycle(($urandom_range(3) == 0) ? N'(0) : N'($urandom), d, $urandom_range(3) == 0);
      end
    end
    cycle(4'b0000, '0, 1'b0);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
